// File: rtl/operand_fetch_unit.sv
// -----------------------------------------------------------------------------
// operand_fetch_unit
//
// Issue-side reader of the architectural register file. It holds the 8x16
// register file, which both writeback ports write. It reads the source
// operands of a dual-issue instruction pair, with same-cycle bypass from the
// writeback ports, and tracks pending destinations in a busy scoreboard. The
// operands go to execute in a registered packet. The unit also exports the
// packed register image that the writeback units consume.
//
// Ports
//   clk, rst                       rising-edge clock, async active-high reset
//   in_valid / in_ready            decode handshake (in_ready combinational)
//   instr0, instr1                 rd=[10:8], rs1=[7:5], rs2=[4:2]
//   slot1_valid                    slot 1 carries a real instruction
//   iswb0, iswb1                   slot writes its rd
//   wb{0,1}_en/_rd/_data           writeback ports (wb1 wins on collision)
//   out_valid / out_ready          execute handshake
//   out_instr{0,1}, out_v{0,1}     issued instructions and their valid bits
//   out_a{0,1}, out_b{0,1}         rs1 / rs2 operands per slot
//   regvalwb                       packed register image, reg i at [16i+15:16i]
// -----------------------------------------------------------------------------
module operand_fetch_unit #(
    parameter int NREG = 8,          // register index fields are 3 bits wide
    parameter int DW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          instr0,
    input  logic [15:0]          instr1,
    input  logic                 slot1_valid,
    input  logic                 iswb0,
    input  logic                 iswb1,
    input  logic                 wb0_en,
    input  logic [2:0]           wb0_rd,
    input  logic [DW-1:0]        wb0_data,
    input  logic                 wb1_en,
    input  logic [2:0]           wb1_rd,
    input  logic [DW-1:0]        wb1_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_instr0,
    output logic [15:0]          out_instr1,
    output logic                 out_v0,
    output logic                 out_v1,
    output logic [DW-1:0]        out_a0,
    output logic [DW-1:0]        out_b0,
    output logic [DW-1:0]        out_a1,
    output logic [DW-1:0]        out_b1,
    output logic [NREG*DW-1:0]   regvalwb
);

    typedef enum logic {PAIR, SPLIT} state_t;

    state_t            state, next_state;
    logic [DW-1:0]     regs [NREG];
    logic [NREG-1:0]   busy, busy_nxt, set_mask;
    logic [NREG-1:0]   wr_hit;    // register written by some wb port this cycle
    logic [NREG-1:0]   pending;   // busy and not resolved by this cycle's writes
    logic [DW-1:0]     byp [NREG];

    logic [2:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
    logic       clear0, clear1, hazard, free;
    logic       issue0, issue1;

    assign rd0   = instr0[10:8];
    assign rs1_0 = instr0[7:5];
    assign rs2_0 = instr0[4:2];
    assign rd1   = instr1[10:8];
    assign rs1_1 = instr1[7:5];
    assign rs2_1 = instr1[4:2];

    // Per-register bypass view: wb1 data over wb0 data over the stored value.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            wr_hit[i] = (wb0_en && wb0_rd == 3'(i)) || (wb1_en && wb1_rd == 3'(i));
            if (wb1_en && wb1_rd == 3'(i))
                byp[i] = wb1_data;
            else if (wb0_en && wb0_rd == 3'(i))
                byp[i] = wb0_data;
            else
                byp[i] = regs[i];
        end
    end

    // A busy register being written on this edge counts as available.
    assign pending = busy & ~wr_hit;

    assign clear0 = !pending[rs1_0] && !pending[rs2_0] && !(iswb0 && pending[rd0]);
    assign clear1 = !pending[rs1_1] && !pending[rs2_1] && !(iswb1 && pending[rd1]);
    assign hazard = iswb0 && (rd0 == rs1_1 || rd0 == rs2_1 || rd0 == rd1);
    assign free   = !out_valid || out_ready;

    // Issue control
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        next_state = state;
        in_ready   = 1'b0;
        issue0     = 1'b0;
        issue1     = 1'b0;
        case (state)
            PAIR: begin
                if (in_valid && free && clear0) begin
                    issue0 = 1'b1;
                    if (!slot1_valid || (clear1 && !hazard)) begin
                        issue1   = slot1_valid;
                        in_ready = 1'b1;
                    end else begin
                        // Slot 1 waits alone; decode keeps it on instr1.
                        next_state = SPLIT;
                    end
                end
            end
            SPLIT: begin
                if (free && clear1) begin
                    issue1     = 1'b1;
                    in_ready   = 1'b1;
                    next_state = PAIR;
                end
            end
            default: next_state = PAIR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PAIR;
        else     state <= next_state;
    end

    // Scoreboard: writes clear, issues set; a set on the same edge wins.
    always_comb begin
        set_mask = '0;
        if (issue0 && iswb0) set_mask[rd0] = 1'b1;
        if (issue1 && iswb1) set_mask[rd1] = 1'b1;
        busy_nxt = (busy & ~wr_hit) | set_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // Register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is architecturally zero after reset, so
            // it is built from resettable flops rather than an un-reset RAM.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            // NOTE: non-blocking writes; when both ports hit the same register,
            // the later assignment (wb1) is the one that takes effect.
            if (wb0_en) regs[wb0_rd] <= wb0_data;
            if (wb1_en) regs[wb1_rd] <= wb1_data;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) regvalwb[i*DW +: DW] = regs[i];
    end

    // Output packet register. It loads whenever it is free. Operand fields of
    // a slot that did not issue are zeroed, and the packet holds while execute
    // back-pressures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_v0     <= 1'b0;
            out_v1     <= 1'b0;
            out_instr0 <= '0;
            out_instr1 <= '0;
            out_a0     <= '0;
            out_b0     <= '0;
            out_a1     <= '0;
            out_b1     <= '0;
        end else if (free) begin
            out_valid <= issue0 || issue1;
            out_v0    <= issue0;
            out_v1    <= issue1;
            if (issue0 || issue1) begin
                out_instr0 <= issue0 ? instr0 : '0;
                out_a0     <= issue0 ? byp[rs1_0] : '0;
                out_b0     <= issue0 ? byp[rs2_0] : '0;
                out_instr1 <= issue1 ? instr1 : '0;
                out_a1     <= issue1 ? byp[rs1_1] : '0;
                out_b1     <= issue1 ? byp[rs2_1] : '0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
module tb_operand_fetch_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, slot1_valid, iswb0, iswb1;
    logic [15:0]  instr0, instr1;
    logic         wb0_en, wb1_en;
    logic [2:0]   wb0_rd, wb1_rd;
    logic [15:0]  wb0_data, wb1_data;
    logic         out_valid, out_ready, out_v0, out_v1;
    logic [15:0]  out_instr0, out_instr1, out_a0, out_b0, out_a1, out_b1;
    logic [127:0] regvalwb;

    int n_tests = 0;
    int n_fail  = 0;

    operand_fetch_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr0(instr0), .instr1(instr1), .slot1_valid(slot1_valid),
        .iswb0(iswb0), .iswb1(iswb1),
        .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr0(out_instr0), .out_instr1(out_instr1),
        .out_v0(out_v0), .out_v1(out_v1),
        .out_a0(out_a0), .out_b0(out_b0), .out_a1(out_a1), .out_b1(out_b1),
        .regvalwb(regvalwb)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_reg [8];
    logic [7:0]  m_busy;
    bit          m_split;       // waiting to send the held slot 1
    bit          m_last_ready;  // model in_ready of the last cycle run
    logic        seen_ready;    // DUT in_ready sampled before the last edge
    bit          e_valid, e_v0, e_v1;
    logic [15:0] e_i0, e_i1, e_a0, e_b0, e_a1, e_b1;

    function automatic logic [15:0] mk(input int rd, input int rs1, input int rs2);
        return 16'((rd << 8) | (rs1 << 5) | (rs2 << 2));
    endfunction

    function automatic logic [15:0] m_src(input logic [2:0] r);
        logic [15:0] v;
        v = m_reg[r];
        if (wb0_en && wb0_rd == r) v = wb0_data;
        if (wb1_en && wb1_rd == r) v = wb1_data;
        return v;
    endfunction

    function automatic bit m_waiting(input logic [2:0] r);
        return m_busy[r] && !(wb0_en && wb0_rd == r) && !(wb1_en && wb1_rd == r);
    endfunction

    function automatic bit m_slot_ok(input logic [15:0] ins, input bit wr);
        return !m_waiting(ins[7:5]) && !m_waiting(ins[4:2]) && !(wr && m_waiting(ins[10:8]));
    endfunction

    function automatic bit m_pair_hazard();
        return iswb0 && (instr0[10:8] == instr1[7:5] || instr0[10:8] == instr1[4:2] ||
                         instr0[10:8] == instr1[10:8]);
    endfunction

    function automatic logic [127:0] m_image();
        logic [127:0] img;
        for (int i = 0; i < 8; i++) img[i*16 +: 16] = m_reg[i];
        return img;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_busy = '0; m_split = 0; m_last_ready = 0;
        e_valid = 0; e_v0 = 0; e_v1 = 0;
        e_i0 = '0; e_i1 = '0; e_a0 = '0; e_b0 = '0; e_a1 = '0; e_b1 = '0;
    endtask

    task automatic idle_inputs();
        in_valid = 0; slot1_valid = 0; iswb0 = 0; iswb1 = 0;
        instr0 = '0; instr1 = '0;
        wb0_en = 0; wb1_en = 0; wb0_rd = '0; wb1_rd = '0; wb0_data = '0; wb1_data = '0;
    endtask

    // One clock: inputs were driven just before the call (posedge+1 phase).
    task automatic run_cycle(input string tag);
        bit free, go0, go1, exp_ready;
        free = !e_valid || out_ready;
        go0 = 0; go1 = 0; exp_ready = 0;
        if (!m_split) begin
            if (in_valid && free && m_slot_ok(instr0, iswb0)) begin
                go0 = 1;
                if (!slot1_valid || (m_slot_ok(instr1, iswb1) && !m_pair_hazard())) begin
                    go1 = slot1_valid;
                    exp_ready = 1;
                end
            end
        end else if (free && m_slot_ok(instr1, iswb1)) begin
            go1 = 1;
            exp_ready = 1;
        end
        #1;
        seen_ready = in_ready;
        n_tests++;
        if (in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL %s in_ready: got %b want %b", tag, in_ready, exp_ready);
        end
        @(posedge clk);
        // packet (read before the register file changes)
        if (free) begin
            e_valid = go0 || go1; e_v0 = go0; e_v1 = go1;
            if (go0) begin e_i0 = instr0; e_a0 = m_src(instr0[7:5]); e_b0 = m_src(instr0[4:2]); end
            if (go1) begin e_i1 = instr1; e_a1 = m_src(instr1[7:5]); e_b1 = m_src(instr1[4:2]); end
        end
        if (wb0_en) begin m_reg[wb0_rd] = wb0_data; m_busy[wb0_rd] = 0; end
        if (wb1_en) begin m_reg[wb1_rd] = wb1_data; m_busy[wb1_rd] = 0; end
        if (go0 && iswb0) m_busy[instr0[10:8]] = 1;
        if (go1 && iswb1) m_busy[instr1[10:8]] = 1;
        if (!m_split && go0 && !exp_ready) m_split = 1;
        else if (m_split && go1)           m_split = 0;
        m_last_ready = exp_ready;
        #1;
        n_tests++;
        if ({out_valid, out_v0, out_v1} !== {e_valid, e_v0, e_v1}) begin
            n_fail++;
            $display("FAIL %s valid/v0/v1: got %b%b%b want %b%b%b", tag,
                     out_valid, out_v0, out_v1, e_valid, e_v0, e_v1);
        end
        if (e_v0) begin
            n_tests++;
            if ({out_instr0, out_a0, out_b0} !== {e_i0, e_a0, e_b0}) begin
                n_fail++;
                $display("FAIL %s slot0 instr/a/b: got %h %h %h want %h %h %h", tag,
                         out_instr0, out_a0, out_b0, e_i0, e_a0, e_b0);
            end
        end
        if (e_v1) begin
            n_tests++;
            if ({out_instr1, out_a1, out_b1} !== {e_i1, e_a1, e_b1}) begin
                n_fail++;
                $display("FAIL %s slot1 instr/a/b: got %h %h %h want %h %h %h", tag,
                         out_instr1, out_a1, out_b1, e_i1, e_a1, e_b1);
            end
        end
        n_tests++;
        if (regvalwb !== m_image()) begin
            n_fail++;
            $display("FAIL %s regvalwb: got %h want %h", tag, regvalwb, m_image());
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1;
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({out_valid, out_v0, out_v1} !== 3'b000 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid/v0/v1/in_ready %b%b%b%b want 0000",
                     out_valid, out_v0, out_v1, in_ready);
        end
        n_tests++;
        if ({out_instr0, out_instr1, out_a0, out_b0, out_a1, out_b1} !== 96'h0 || regvalwb !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h %h %h img %h want all zero",
                     out_instr0, out_instr1, out_a0, out_b0, out_a1, out_b1, regvalwb);
        end
    endtask

    task automatic test_first_read();
        instr0 = mk(0, 1, 2); in_valid = 1;
        run_cycle("first_read");
        in_valid = 0;
        n_tests++;
        if (out_valid !== 1'b1 || out_a0 !== 16'h0000 || out_b0 !== 16'h0000 || regvalwb !== 128'h0) begin
            n_fail++;
            $display("FAIL first_read: got valid %b a0 %h b0 %h img %h want 1 0000 0000 0",
                     out_valid, out_a0, out_b0, regvalwb);
        end
    endtask

    task automatic test_bypass();
        wb0_en = 1; wb0_rd = 3; wb0_data = 16'hBEEF;
        instr0 = mk(0, 3, 0); in_valid = 1;
        run_cycle("bypass");
        wb0_en = 0; in_valid = 0;
        n_tests++;
        if (out_a0 !== 16'hBEEF || regvalwb[63:48] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass: got a0 %h r3 %h want beef beef", out_a0, regvalwb[63:48]);
        end
    endtask

    task automatic test_wb_collide();
        wb0_en = 1; wb0_rd = 5; wb0_data = 16'h1111;
        wb1_en = 1; wb1_rd = 5; wb1_data = 16'h2222;
        instr0 = mk(0, 5, 5); in_valid = 1;
        run_cycle("wb_collide");
        wb0_en = 0; wb1_en = 0; in_valid = 0;
        n_tests++;
        if (regvalwb[95:80] !== 16'h2222 || out_a0 !== 16'h2222) begin
            n_fail++;
            $display("FAIL wb_collide: got r5 %h a0 %h want 2222 2222", regvalwb[95:80], out_a0);
        end
    endtask

    task automatic test_split();
        instr0 = mk(4, 0, 0); iswb0 = 1;
        instr1 = mk(1, 4, 0); iswb1 = 0; slot1_valid = 1; in_valid = 1;
        run_cycle("split_a");
        n_tests++;
        if (out_v0 !== 1'b1 || out_v1 !== 1'b0 || seen_ready !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL split_first: got v0 %b v1 %b ready %b/%b want 1 0 0/0",
                     out_v0, out_v1, seen_ready, in_ready);
        end
        wb0_en = 1; wb0_rd = 4; wb0_data = 16'h00AA;
        run_cycle("split_b");
        wb0_en = 0; in_valid = 0; slot1_valid = 0; iswb0 = 0;
        n_tests++;
        if (out_v0 !== 1'b0 || out_v1 !== 1'b1 || out_a1 !== 16'h00AA || seen_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL split_second: got v0 %b v1 %b a1 %h ready %b want 0 1 00aa 1",
                     out_v0, out_v1, out_a1, seen_ready);
        end
    endtask

    task automatic test_stall_hold();
        instr0 = mk(6, 0, 0); iswb0 = 1; in_valid = 1;
        run_cycle("stall_issue");
        instr0 = mk(0, 6, 1); iswb0 = 0;
        for (int c = 0; c < 3; c++) begin
            run_cycle("stall_wait");
            n_tests++;
            if (seen_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_wait: got ready %b valid %b want 0 0", seen_ready, out_valid);
            end
        end
        wb0_en = 1; wb0_rd = 6; wb0_data = 16'h6666;
        run_cycle("stall_release");
        wb0_en = 0;
        n_tests++;
        if (seen_ready !== 1'b1 || out_a0 !== 16'h6666) begin
            n_fail++;
            $display("FAIL stall_release: got ready %b a0 %h want 1 6666", seen_ready, out_a0);
        end
        out_ready = 0;
        instr0 = mk(2, 3, 4); iswb0 = 1;
        for (int c = 0; c < 3; c++) begin
            run_cycle("hold");
            n_tests++;
            if (out_valid !== 1'b1 || out_a0 !== 16'h6666 || out_instr0 !== mk(0, 6, 1) || seen_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: got valid %b a0 %h instr0 %h ready %b want 1 6666 %h 0",
                         out_valid, out_a0, out_instr0, seen_ready, mk(0, 6, 1));
            end
        end
        out_ready = 1;
        run_cycle("hold_release");
        in_valid = 0; iswb0 = 0;
        n_tests++;
        if (seen_ready !== 1'b1 || out_a0 !== 16'hBEEF || out_b0 !== 16'h00AA) begin
            n_fail++;
            $display("FAIL hold_release: got ready %b a0 %h b0 %h want 1 beef 00aa",
                     seen_ready, out_a0, out_b0);
        end
    endtask

    task automatic test_reset_split();
        instr0 = mk(7, 0, 0); iswb0 = 1;
        instr1 = mk(1, 7, 0); iswb1 = 0; slot1_valid = 1; in_valid = 1;
        run_cycle("rsplit_enter");
        rst = 1;
        idle_inputs();
        model_reset();
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_v0 !== 1'b0 || regvalwb !== 128'h0) begin
            n_fail++;
            $display("FAIL rsplit_async: got valid %b v0 %b img %h want 0 0 0", out_valid, out_v0, regvalwb);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        instr0 = mk(7, 7, 0); iswb0 = 1;
        instr1 = mk(1, 7, 0); slot1_valid = 0; in_valid = 1;
        run_cycle("rsplit_after");
        in_valid = 0; iswb0 = 0;
        n_tests++;
        if (seen_ready !== 1'b1 || out_v0 !== 1'b1 || out_v1 !== 1'b0 || out_a0 !== 16'h0) begin
            n_fail++;
            $display("FAIL rsplit_after: got ready %b v0 %b v1 %b a0 %h want 1 1 0 0000",
                     seen_ready, out_v0, out_v1, out_a0);
        end
    endtask

    function automatic logic [2:0] pick_reg();
        int start;
        start = $urandom_range(0, 7);
        if (m_busy != '0 && $urandom_range(0, 3) != 0)
            for (int k = 0; k < 8; k++)
                if (m_busy[(start + k) % 8]) return 3'((start + k) % 8);
        return 3'(start);
    endfunction

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            // Stalled inputs stay put; otherwise decode may offer something new.
            if (m_last_ready || !in_valid) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                instr0      = 16'($urandom);
                instr1      = 16'($urandom);
                slot1_valid = 1'($urandom);
                iswb0       = 1'($urandom);
                iswb1       = 1'($urandom);
            end
            wb0_en = ($urandom_range(0, 1) == 0); wb0_rd = pick_reg(); wb0_data = 16'($urandom);
            wb1_en = ($urandom_range(0, 2) == 0); wb1_rd = pick_reg(); wb1_data = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            run_cycle("random");
        end
        idle_inputs();
        out_ready = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_read();
        test_bypass();
        test_wb_collide();
        test_split();
        test_stall_hold();
        test_reset_split();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Issue-side reader for the architectural register file; it is the other end of the writeback path.
- Holds the 8x16 register file and accepts two writeback ports, one per pipe.
- Fetches source operands for a dual-issue instruction pair and tracks pending destinations with a scoreboard.
- Presents a registered operand packet to execute and exports the packed register image that the writeback units consume.

Parameters:
- NREG, 8, number of architectural registers (register index width 3).
- DW, 16, register/data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decode presents an instruction pair.
- in_ready  out  1  pair (or its remaining slot 1) consumed this cycle.
- instr0  in  16  slot 0 instruction; rd=[10:8], rs1=[7:5], rs2=[4:2].
- instr1  in  16  slot 1 instruction; same fields as slot 0.
- slot1_valid  in  1  slot 1 carries a real instruction.
- iswb0  in  1  slot 0 writes rd.
- iswb1  in  1  slot 1 writes rd.
- wb0_en  in  1  writeback port 0 write enable.
- wb0_rd  in  3  writeback port 0 destination register.
- wb0_data  in  16  writeback port 0 data.
- wb1_en  in  1  writeback port 1 write enable.
- wb1_rd  in  3  writeback port 1 destination register.
- wb1_data  in  16  writeback port 1 data.
- out_valid  out  1  operand packet valid.
- out_ready  in  1  execute accepts the packet.
- out_instr0  out  16  issued slot 0 instruction.
- out_instr1  out  16  issued slot 1 instruction.
- out_v0  out  1  out_instr0 valid.
- out_v1  out  1  out_instr1 valid.
- out_a0  out  16  slot 0 rs1 operand.
- out_b0  out  16  slot 0 rs2 operand.
- out_a1  out  16  slot 1 rs1 operand.
- out_b1  out  16  slot 1 rs2 operand.
- regvalwb  out  128  packed register image; reg i at [16i+15:16i], registered.

Behaviour:
Reset:
- All registers = 0; busy[7:0] = 0; state = PAIR.
- out_valid, out_v0, out_v1 = 0; all out_* data = 0.
- Async assertion mid-packet discards the packet; no partial scoreboard state is kept.

Register writes:
- Both ports write on the clock edge.
- When wb0_rd == wb1_rd and both are enabled, wb1 wins.
- Each write clears busy[rd] unless the same edge sets it (see scoreboard).

Operand read:
- Combinational read with same-cycle bypass: a source matching an enabled wb rd takes that wb data, wb1 over wb0.
- Operands are captured into the output register: latency 1 cycle from acceptance to out_valid.

Scoreboard, per slot:
- A slot is "clear" when each of rs1, rs2, and rd (if iswb) is not busy, or is being written by a wb port this cycle.
- On issue with iswb, busy[rd] is set.
- Set beats clear on the same edge.

Output handshake:
- Output register is free when !out_valid | out_ready.
- Output holds its value while out_valid & !out_ready.

FSM:
- PAIR:
  - in_valid & free & slot0 clear & (!slot1_valid | (slot1 clear & no intra-pair hazard)) -> issue both (out_v1 = slot1_valid), in_ready = 1, stay in PAIR.
  - Intra-pair hazard: iswb0 and instr0.rd equals instr1.rs1, instr1.rs2, or instr1.rd.
  - If slot0 is clear but slot1 is blocked -> issue slot0 only (out_v0 = 1, out_v1 = 0), in_ready = 0, go to SPLIT.
  - Otherwise stall; in_ready = 0.
- SPLIT:
  - Decode holds instr1 stable.
  - free & slot1 clear -> issue slot1 only (out_v0 = 0, out_v1 = 1), in_ready = 1, go to PAIR.
  - Otherwise stall.
- in_ready is combinational.
- Stalled inputs must stay stable; violating this is undefined.

regvalwb:
- Reflects the register file after each edge.
- No bypass onto regvalwb.

Test Plan:
- Reset, then instr0 rs1=r1, rs2=r2, no wb -> one cycle later out_valid=1, out_a0=0x0000, out_b0=0x0000; regvalwb=0.
- wb0_en, rd=3, data=0xBEEF in the same cycle as issuing instr0 with rs1=r3 -> out_a0=0xBEEF (bypass); next cycle regvalwb[63:48]=0xBEEF.
- wb0 and wb1 both to r5 with data 0x1111 and 0x2222 -> r5=0x2222.
- Pair: instr0 rd=r4 with iswb0; instr1 rs1=r4 -> slot0 issues alone, state SPLIT, in_ready=0. Then wb0 r4=0x00AA -> slot1 issues with out_a1=0x00AA, in_ready=1.
- Issue rd=r6 (busy), then the next pair reads r6 -> stall until wb r6 arrives. With out_ready=0 held for 3 cycles, out_* are unchanged and no new issue occurs.
- Assert rst while in SPLIT with busy bits set -> busy=0, out_valid=0, state=PAIR, all registers 0.
